// File: rtl/sigdel_core.sv
// Sigma-delta bitstream decimator: clock-enable divider, SINC1/SINC2/SINC3
// decimation filters, 16-bit normalisation with saturation, and a PWM rendering of the result.
module sigdel_core #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inp,
  output logic [7:0] out
);

  logic [CNT_W-1:0] cnt;
  logic [7:0]       en;
  logic [1:0]       fs_sel;
  logic [1:0]       osr_sel;
  logic [1:0]       flt_sel;
  logic [2:0]       bw_idx;
  logic             din;
  logic             fs;
  logic             bw;

  assign din     = inp[0];
  assign fs_sel  = inp[2:1];
  assign osr_sel = inp[4:3];
  assign flt_sel = inp[6:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CNT_W'(1);
  end

  // en[k] pulses once every 4^(k+1) clocks, when the low 2k+2 counter bits are all ones.
  for (genvar k = 0; k < 8; k++) begin : g_en
    assign en[k] = &cnt[2*k+1:0];
  end

  assign bw_idx = 3'({1'b0, fs_sel}) + 3'({1'b0, osr_sel}) + 3'd1;
  assign fs     = en[fs_sel];
  assign bw     = en[bw_idx];

  logic [ACC_W-1:0] din_ext;
  assign din_ext = ACC_W'(din);

  // SINC1: window counter; the sample arriving with bw closes the current window.
  logic [ACC_W-1:0] s1_cnt;
  logic [ACC_W-1:0] s1_next;
  assign s1_next = fs ? (s1_cnt + din_ext) : s1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  s1_cnt <= '0;
    else if (bw) s1_cnt <= '0;
    else if (fs) s1_cnt <= s1_next;
  end

  // Cascaded integrators; each stage feeds the freshly updated value downstream.
  logic [ACC_W-1:0] int1, int2, int3;
  logic [ACC_W-1:0] int1_n, int2_n, int3_n;
  assign int1_n = int1 + din_ext;
  assign int2_n = int2 + int1_n;
  assign int3_n = int3 + int2_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
    end else if (fs) begin
      int1 <= int1_n;
      int2 <= int2_n;
      int3 <= int3_n;
    end
  end

  // Separate comb chains for SINC2 and SINC3; modular wrap of the integrators cancels out here.
  logic [ACC_W-1:0] d2a, d2b;
  logic [ACC_W-1:0] d3a, d3b, d3c;
  logic [ACC_W-1:0] c2a, c2b;
  logic [ACC_W-1:0] c3a, c3b, c3c;
  assign c2a = int2_n - d2a;
  assign c2b = c2a - d2b;
  assign c3a = int3_n - d3a;
  assign c3b = c3a - d3b;
  assign c3c = c3b - d3c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2a <= '0;
      d2b <= '0;
      d3a <= '0;
      d3b <= '0;
      d3c <= '0;
    end else if (bw) begin
      d2a <= int2_n;
      d2b <= c2a;
      d3a <= int3_n;
      d3b <= c3a;
      d3c <= c3b;
    end
  end

  logic [ACC_W-1:0] raw;
  logic [2:0]       n_ord;
  logic [2:0]       q_ord;
  logic [5:0]       qn2;

  always_comb begin
    raw   = s1_next;
    n_ord = 3'd1;
    case (flt_sel)
      2'b01: begin
        raw   = c2b;
        n_ord = 3'd2;
      end
      2'b10: begin
        raw   = c3c;
        n_ord = 3'd3;
      end
      default: begin
        raw   = s1_next;
        n_ord = 3'd1;
      end
    endcase
  end

  assign q_ord = 3'({1'b0, osr_sel}) + 3'd1;
  assign qn2   = 6'(q_ord) * 6'(n_ord) * 6'd2;

  // raw * 2^16 / M^N: shifting left by 16 then right by 2qN covers both shift directions.
  logic [ACC_W+15:0] scaled;
  logic [15:0]       norm;
  assign scaled = {raw, 16'h0000} >> qn2;
  assign norm   = (|scaled[ACC_W+15:16]) ? 16'hFFFF : scaled[15:0];

  logic [15:0] res_next;
  assign res_next = (flt_sel == 2'b11) ? {cnt[15:8], en} : norm;

  logic [15:0] res;
  logic        din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      din_q <= 1'b0;
    end else begin
      if (bw) res   <= res_next;
      if (fs) din_q <= din;
    end
  end

  // PWM width is taken at cnt==0 and used from that very cycle, so each period sees one width.
  logic [9:0] pwm_w;
  logic [9:0] pwm_w_eff;
  logic       cnt_zero;
  logic       pwm;
  assign cnt_zero  = (cnt == '0);
  assign pwm_w_eff = cnt_zero ? res[15:6] : pwm_w;
  assign pwm       = (cnt[15:6] < pwm_w_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pwm_w <= '0;
    else if (cnt_zero) pwm_w <= res[15:6];
  end

  assign out = {din_q, pwm, (inp[7] ? res[15:10] : res[5:0])};

endmodule

// File: tb/tb_sigdel_core.sv
// Bench for sigdel_core: directed and random bitstreams checked against a model that
// computes each result as a weighted window sum over the recorded sample history.
module tb_sigdel_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inp = 8'h00;
  logic [7:0] out;

  sigdel_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inp   (inp),
    .out   (out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  int          t;
  int          samp_q[$];
  int          wts[$];
  logic [15:0] r_exp;
  logic [9:0]  w_exp;
  logic        din_exp;
  int          bw_seen;
  int          f_sel, o_sel, m_sel, n_ord, din_mode;
  int          pwm_hi;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic next_din(input int idx);
    case (din_mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (idx % 2 == 0);
      4:       return (idx % 3 != 2);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Filter output = samples convolved with N cascaded boxcars of length M.
  task automatic build_weights(input int m, input int n);
    int nw[$];
    wts.delete();
    for (int i = 0; i < m; i++) wts.push_back(1);
    for (int s = 1; s < n; s++) begin
      nw.delete();
      for (int j = 0; j < wts.size() + m - 1; j++) begin
        int acc = 0;
        for (int i = 0; i < m; i++)
          if (j - i >= 0 && j - i < wts.size()) acc += wts[j - i];
        nw.push_back(acc);
      end
      wts = nw;
    end
  endtask

  function automatic int model_raw();
    int acc = 0;
    int sz = samp_q.size();
    for (int k = 0; k < wts.size() && k < sz; k++) acc += wts[k] * samp_q[sz - 1 - k];
    return acc;
  endfunction

  function automatic logic [15:0] normalise(input int raw, input int q, input int n);
    longint v;
    int s;
    s = 16 - 2 * q * n;
    if (s >= 0) v = longint'(raw) << s;
    else        v = longint'(raw) >> (-s);
    return (v >= 65536) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic bit r_valid();
    if (m_sel == 3) return bw_seen >= 1;
    return bw_seen >= n_ord + 1;
  endfunction

  task automatic model_reset();
    t = 0;
    samp_q.delete();
    r_exp = '0;
    w_exp = '0;
    din_exp = 1'b0;
    bw_seen = 0;
    pwm_hi = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", 16'(out), 16'h0000);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic start_cfg(input int f, input int o, input int flt, input int mode);
    f_sel = f;
    o_sel = o;
    m_sel = flt;
    din_mode = mode;
    n_ord = (flt == 0) ? 1 : (flt == 1) ? 2 : 3;
    inp = {1'b0, 2'(flt), 2'(o), 2'(f), 1'b0};
    build_weights(4 ** (o + 1), n_ord);
    do_reset();
  endtask

  // One clock: decide this cycle's strobes from the cycle count, advance, then check at negedge.
  task automatic tick();
    int cnt, b, cnt2;
    logic [7:0] en_v;
    logic fs, bw, din_v;
    logic [15:0] r_next;
    cnt = t % 65536;
    b = f_sel + o_sel + 1;
    for (int k = 0; k < 8; k++) en_v[k] = ((cnt + 1) % (4 ** (k + 1)) == 0);
    fs = en_v[f_sel];
    bw = en_v[b];
    din_v = next_din(samp_q.size());
    inp[0] = din_v;
    if (fs) samp_q.push_back(int'(din_v));
    r_next = r_exp;
    if (bw) begin
      if (m_sel == 3) r_next = {8'(cnt >> 8), en_v};
      else            r_next = normalise(model_raw(), o_sel + 1, n_ord);
    end
    @(posedge clk);
    #1;
    t++;
    if (fs) din_exp = din_v;
    if (bw) begin
      r_exp = r_next;
      bw_seen++;
    end
    @(negedge clk);
    cnt2 = t % 65536;
    if (cnt2 == 0) w_exp = r_exp[15:6];
    check("din_q", 16'(out[7]), 16'(din_exp));
    check("pwm", 16'(out[6]), 16'((cnt2 >> 6) < int'(w_exp)));
    pwm_hi += int'(out[6]);
    if (r_valid()) begin
      check("r_lo", 16'(out[5:0]), 16'(r_exp[5:0]));
      if (bw) begin
        inp[7] = 1'b1;
        #1;
        check("r_hi", 16'(out[5:0]), 16'(r_exp[15:10]));
        inp[7] = 1'b0;
        #1;
      end
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    f_sel = 0;
    o_sel = 0;
    m_sel = 0;
    n_ord = 1;
    din_mode = 1;
    repeat (3) @(negedge clk);
    check("por_out", 16'(out), 16'h0000);

    // bypass: divider strobes visible in the result
    start_cfg(0, 0, 3, 0);
    run_ticks(16);
    check("byp_first_en", 16'(out[5:0]), 16'h0003);
    run_ticks(300);
    start_cfg(0, 1, 3, 0);
    run_ticks(200);

    // SINC2 OSR16, din=1: saturates
    start_cfg(0, 1, 1, 2);
    run_ticks(64 * 5);
    check("s2_sat_lo", 16'(out[5:0]), 16'h003F);
    inp[7] = 1'b1;
    #1;
    check("s2_sat_hi", 16'(out[5:0]), 16'h003F);
    inp[7] = 1'b0;

    // SINC3, din=0: zero result, PWM never high
    start_cfg(0, 1, 2, 1);
    run_ticks(64 * 6);
    check("s3_zero", 16'(out[5:0]), 16'h0000);
    check("s3_pwm_hi_cnt", 16'(pwm_hi), 16'h0000);

    // SINC2 OSR16 with 110 pattern: ~0xAAAA
    start_cfg(0, 1, 1, 4);
    run_ticks(64 * 6);
    check("s2_23_lo", 16'(out[5:0]), 16'h0000);
    inp[7] = 1'b1;
    #1;
    check("s2_23_hi", 16'(out[5:0]), 16'h002A);
    inp[7] = 1'b0;

    // random configurations and bitstreams
    for (int r = 0; r < 6; r++) begin
      int f, o, flt;
      f = $urandom_range(0, 1);
      o = $urandom_range(0, 2 - f);
      flt = $urandom_range(0, 3);
      start_cfg(f, o, flt, 0);
      run_ticks((4 ** (f + o + 2)) * 5);
    end

    // asynchronous reset mid-window, then recovery
    start_cfg(0, 0, 0, 2);
    run_ticks(40);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 16'(out), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    start_cfg(0, 1, 2, 0);
    run_ticks(64 * 6);

    // SINC1 OSR4, toggling din: R=0x8000, PWM width 512 over a full period
    start_cfg(0, 0, 0, 3);
    run_ticks(65536);
    check("s1_half_lo", 16'(out[5:0]), 16'h0000);
    inp[7] = 1'b1;
    #1;
    check("s1_half_hi", 16'(out[5:0]), 16'h0020);
    inp[7] = 1'b0;
    pwm_hi = 0;
    run_ticks(600);
    check("s1_pwm_hi_cnt", 16'(pwm_hi), 16'd600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
